// File: rtl/hwpe_ctrl_uloop_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hwpe_ctrl_uloop_seq_pkg                                      |
// | Description : Shared types for the uloop sequencer: uloop control/flag     |
// |               structs, sequencer state encoding and sequencer side-band    |
// |               control/status structs.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package hwpe_ctrl_uloop_seq_pkg;

  localparam int unsigned ULOOP_MAX_NB_LOOPS      = 3;
  localparam int unsigned ULOOP_MAX_NB_REG        = 4;
  localparam int unsigned ULOOP_MAX_REG_WIDTH     = 16;
  localparam int unsigned ULOOP_MAX_CNT_WIDTH     = 8;
  localparam int unsigned ULOOP_LOOP_WIDTH        = $clog2(ULOOP_MAX_NB_LOOPS);
  localparam int unsigned ULOOP_SEQ_MAX_CONSUMERS = 8;
  localparam int unsigned ULOOP_SEQ_ITER_WIDTH    = 16;

  // Control toward the uloop engine.
  typedef struct packed {
    logic enable;
    logic clear;
    logic ready;
  } ctrl_uloop_t;

  // Flags produced by the uloop engine for each iteration.
  typedef struct packed {
    logic                                                   valid;
    logic                                                   done;
    logic [ULOOP_MAX_NB_REG-1:0][ULOOP_MAX_REG_WIDTH-1:0]   offs;
    logic [ULOOP_MAX_NB_LOOPS-1:0][ULOOP_MAX_CNT_WIDTH-1:0] idx;
    logic [ULOOP_LOOP_WIDTH-1:0]                            loop;
  } flags_uloop_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    STEP = 3'd2,
    DISP = 3'd3,
    FIN  = 3'd4,
    ABRT = 3'd5
  } uloop_seq_state_t;

  // Sequencer control as seen from the HWPE FSM.
  typedef struct packed {
    logic                               start;
    logic                               abort;
    logic [ULOOP_SEQ_MAX_CONSUMERS-1:0] cons_en;
  } ctrl_uloop_seq_t;

  // Sequencer status toward the HWPE FSM.
  typedef struct packed {
    logic                            busy;
    logic                            done;
    logic [ULOOP_SEQ_ITER_WIDTH-1:0] iter;
  } flags_uloop_seq_t;

endpackage
`default_nettype wire

// File: rtl/hwpe_ctrl_uloop_seq_bcast.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hwpe_ctrl_uloop_seq_bcast                                    |
// | Description : Broadcast handshake of one offset set toward NB_CONSUMERS    |
// |               streamers. Tracks which enabled consumers have accepted and  |
// |               flags when all of them have.                                 |
// | Ports       : clk_i, rst_ni (sync, active-low), clear_i (sync clear),      |
// |               active_i (dispatch phase), en_i (consumer mask), ready_i,    |
// |               valid_o (per consumer), all_acc_o (set fully accepted)       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hwpe_ctrl_uloop_seq_bcast #(
  parameter int unsigned NB_CONSUMERS = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    active_i,
  input  logic [NB_CONSUMERS-1:0] en_i,
  input  logic [NB_CONSUMERS-1:0] ready_i,
  output logic [NB_CONSUMERS-1:0] valid_o,
  output logic                    all_acc_o
);

  logic [NB_CONSUMERS-1:0] r_acc;
  logic [NB_CONSUMERS-1:0] w_acc_now;

  // Valid is a function of registered state only, never of ready.
  assign valid_o   = active_i ? (en_i & ~r_acc) : '0;
  assign w_acc_now = valid_o & ready_i;
  // An empty mask counts as accepted on the first dispatch cycle.
  assign all_acc_o = active_i && ((r_acc | w_acc_now) == en_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_acc <= '0;
    end else if (active_i) begin
      r_acc <= all_acc_o ? '0 : (r_acc | w_acc_now);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hwpe_ctrl_uloop_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hwpe_ctrl_uloop_seq                                          |
// | Description : Sequencer for the uloop engine. Clears the engine on start,  |
// |               steps it one iteration at a time, latches each iteration's   |
// |               flags and broadcasts them to the enabled streamer consumers. |
// | Ports       : clk_i, rst_ni (sync, active-low), clear_i (soft clear),      |
// |               start_i, abort_i, cons_en_i -> job control                   |
// |               ctrl_uloop_o / flags_uloop_i -> uloop engine                 |
// |               offs_valid_o / offs_ready_i -> consumer handshake            |
// |               offs_o, idx_o, loop_o, last_o -> latched iteration set       |
// |               iter_o, busy_o, done_o -> job status                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hwpe_ctrl_uloop_seq
  import hwpe_ctrl_uloop_seq_pkg::*;
#(
  parameter int unsigned NB_CONSUMERS = 2,
  parameter int unsigned NB_REG       = ULOOP_MAX_NB_REG,
  parameter int unsigned REG_WIDTH    = ULOOP_MAX_REG_WIDTH,
  parameter int unsigned ITER_WIDTH   = 16
) (
  input  logic                                               clk_i,
  input  logic                                               rst_ni,
  input  logic                                               clear_i,
  input  logic                                               start_i,
  input  logic                                               abort_i,
  input  logic [NB_CONSUMERS-1:0]                            cons_en_i,
  output ctrl_uloop_t                                        ctrl_uloop_o,
  input  flags_uloop_t                                       flags_uloop_i,
  output logic [NB_CONSUMERS-1:0]                            offs_valid_o,
  input  logic [NB_CONSUMERS-1:0]                            offs_ready_i,
  output logic [NB_REG*REG_WIDTH-1:0]                        offs_o,
  output logic [ULOOP_MAX_NB_LOOPS*ULOOP_MAX_CNT_WIDTH-1:0]  idx_o,
  output logic [ULOOP_LOOP_WIDTH-1:0]                        loop_o,
  output logic                                               last_o,
  output logic [ITER_WIDTH-1:0]                              iter_o,
  output logic                                               busy_o,
  output logic                                               done_o
);

  uloop_seq_state_t r_state, w_state_nxt;

  logic [NB_CONSUMERS-1:0]                           r_en;
  logic [NB_REG*REG_WIDTH-1:0]                       r_offs, w_offs_cap;
  logic [ULOOP_MAX_NB_LOOPS*ULOOP_MAX_CNT_WIDTH-1:0] r_idx;
  logic [ULOOP_LOOP_WIDTH-1:0]                       r_loop;
  logic                                              r_last;
  logic [ITER_WIDTH-1:0]                             r_iter;

  logic w_flag_hit;
  logic w_disp;
  logic w_all_acc;
  logic w_start_ok;

  assign w_flag_hit = flags_uloop_i.valid | flags_uloop_i.done;
  assign w_disp     = (r_state == DISP);
  // Abort outranks start, so a same-cycle start+abort in IDLE is dropped.
  assign w_start_ok = (r_state == IDLE) && start_i && !abort_i;

  // Only the lowest NB_REG offsets, trimmed to REG_WIDTH, are forwarded.
  generate
    for (genvar g = 0; g < NB_REG; g++) begin : g_offs
      assign w_offs_cap[g*REG_WIDTH +: REG_WIDTH] = flags_uloop_i.offs[g][REG_WIDTH-1:0];
    end
  endgenerate

  hwpe_ctrl_uloop_seq_bcast #(
    .NB_CONSUMERS (NB_CONSUMERS)
  ) i_bcast (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i | abort_i),
    .active_i  (w_disp),
    .en_i      (r_en),
    .ready_i   (offs_ready_i),
    .valid_o   (offs_valid_o),
    .all_acc_o (w_all_acc)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (r_state != IDLE && abort_i) begin
      w_state_nxt = ABRT;
    end else begin
      case (r_state)
        IDLE:    if (w_start_ok) w_state_nxt = CLR;
        CLR:     w_state_nxt = STEP;
        STEP:    if (w_flag_hit) w_state_nxt = DISP;
        DISP:    if (w_all_acc) w_state_nxt = r_last ? FIN : STEP;
        FIN:     w_state_nxt = IDLE;
        ABRT:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_uloop_o        = '0;
    ctrl_uloop_o.enable = (r_state == STEP);
    ctrl_uloop_o.ready  = (r_state == STEP);
    ctrl_uloop_o.clear  = (r_state == CLR) || (r_state == ABRT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_state <= IDLE;
      r_en    <= '0;
      r_offs  <= '0;
      r_idx   <= '0;
      r_loop  <= '0;
      r_last  <= 1'b0;
      r_iter  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_en   <= cons_en_i;
        r_iter <= '0;
      end
      // A done flag, with or without valid, marks the final set.
      if (r_state == STEP && !abort_i && w_flag_hit) begin
        r_offs <= w_offs_cap;
        r_idx  <= flags_uloop_i.idx;
        r_loop <= flags_uloop_i.loop;
        r_last <= flags_uloop_i.done;
      end
      if (w_disp && !abort_i && w_all_acc && !(&r_iter)) begin
        r_iter <= r_iter + ITER_WIDTH'(1);
      end
    end
  end

  assign offs_o = r_offs;
  assign idx_o  = r_idx;
  assign loop_o = r_loop;
  assign last_o = r_last;
  assign iter_o = r_iter;
  assign busy_o = (r_state != IDLE);
  assign done_o = (r_state == FIN);

endmodule
`default_nettype wire

// File: tb/tb_hwpe_ctrl_uloop_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hwpe_ctrl_uloop_seq                                       |
// | Description : Self-checking bench for hwpe_ctrl_uloop_seq with a small     |
// |               uloop responder, delayed-ready consumers and a scoreboard    |
// |               of latched iteration sets.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hwpe_ctrl_uloop_seq;
  import hwpe_ctrl_uloop_seq_pkg::*;

  localparam int OW = ULOOP_MAX_NB_REG * ULOOP_MAX_REG_WIDTH;
  localparam int IW = ULOOP_MAX_NB_LOOPS * ULOOP_MAX_CNT_WIDTH;

  logic                        clk = 1'b0;
  logic                        rst_ni, clear_i, start_i, abort_i;
  logic [1:0]                  cons_en_i, offs_valid_o, offs_ready_i;
  ctrl_uloop_t                 ctrl_uloop_o;
  flags_uloop_t                flags_uloop_i;
  logic [OW-1:0]               offs_o;
  logic [IW-1:0]               idx_o;
  logic [ULOOP_LOOP_WIDTH-1:0] loop_o;
  logic                        last_o, busy_o, done_o;
  logic [15:0]                 iter_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hwpe_ctrl_uloop_seq #(
    .NB_CONSUMERS (2),
    .NB_REG       (ULOOP_MAX_NB_REG),
    .REG_WIDTH    (ULOOP_MAX_REG_WIDTH),
    .ITER_WIDTH   (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .cons_en_i     (cons_en_i),
    .ctrl_uloop_o  (ctrl_uloop_o),
    .flags_uloop_i (flags_uloop_i),
    .offs_valid_o  (offs_valid_o),
    .offs_ready_i  (offs_ready_i),
    .offs_o        (offs_o),
    .idx_o         (idx_o),
    .loop_o        (loop_o),
    .last_o        (last_o),
    .iter_o        (iter_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // uloop responder: answers every enabled cycle unless stalled; the
  // iteration m_cnt == m_steps-1 carries done.
  int unsigned m_steps = 1;
  logic        m_stall = 1'b0;
  logic [7:0]  m_cnt   = 8'd0;

  always_comb begin
    flags_uloop_i = '0;
    for (int r = 0; r < ULOOP_MAX_NB_REG; r++)
      flags_uloop_i.offs[r] = {m_cnt, 8'(r + 1)};
    for (int l = 0; l < ULOOP_MAX_NB_LOOPS; l++)
      flags_uloop_i.idx[l] = m_cnt + 8'(l * 3 + 1);
    flags_uloop_i.loop  = 2'(m_cnt % 8'd3);
    flags_uloop_i.valid = ctrl_uloop_o.enable & ~m_stall;
    flags_uloop_i.done  = ctrl_uloop_o.enable & ~m_stall & ((32'(m_cnt) + 1) == m_steps);
  end

  always @(posedge clk) begin
    if (!rst_ni || ctrl_uloop_o.clear) m_cnt <= 8'd0;
    else if (ctrl_uloop_o.enable && (flags_uloop_i.valid || flags_uloop_i.done)) m_cnt <= m_cnt + 8'd1;
  end

  // Consumers: consumer c accepts once its valid has been up for dly[c] cycles.
  int dly  [2] = '{0, 0};
  int vcnt [2] = '{0, 0};

  always_comb begin
    for (int c = 0; c < 2; c++)
      offs_ready_i[c] = offs_valid_o[c] && (vcnt[c] >= dly[c]);
  end

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++)
      vcnt[c] <= (offs_valid_o[c] && !offs_ready_i[c]) ? vcnt[c] + 1 : 0;
  end

  // Scoreboard: each uloop answer that will be captured is pushed; the set is
  // popped and compared when the DUT first raises a valid for it.
  typedef struct packed {
    logic [OW-1:0]               offs;
    logic [IW-1:0]               idx;
    logic [ULOOP_LOOP_WIDTH-1:0] loop;
    logic                        last;
  } sb_t;

  sb_t        sb_q [$];
  logic [1:0] cur_en   = 2'b00;
  logic       prev_any = 1'b0;

  always @(negedge clk) begin : sb_mon
    sb_t e;
    if (rst_ni && !abort_i && ctrl_uloop_o.enable && cur_en != 2'b00 &&
        (flags_uloop_i.valid || flags_uloop_i.done))
      sb_q.push_back({flags_uloop_i.offs, flags_uloop_i.idx, flags_uloop_i.loop, flags_uloop_i.done});
    if ((|offs_valid_o) && !prev_any) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: valid %0b raised with no expected set", offs_valid_o);
      end else begin
        e = sb_q.pop_front();
        check("sb_offs", offs_o, e.offs);
        check("sb_idx",  idx_o,  e.idx);
        check("sb_loop", loop_o, e.loop);
        check("sb_last", last_o, e.last);
      end
    end
    prev_any = |offs_valid_o;
  end

  typedef struct {
    int         steps;
    logic [1:0] en;
    int         d0;
    int         d1;
    logic       busy_start;
    int         exp_busy;
    int         exp_v0;
    int         exp_v1;
  } job_t;

  job_t jobs [5];

  task automatic run_job(input job_t j);
    int cyc, v0, v1, dn, clr, first_en;
    cyc = 0; v0 = 0; v1 = 0; dn = 0; clr = 0; first_en = 0;
    dly[0] = j.d0; dly[1] = j.d1; m_steps = j.steps; cur_en = j.en;
    @(negedge clk);
    start_i = 1'b1; cons_en_i = j.en;
    @(negedge clk);
    start_i = 1'b0; cons_en_i = ~j.en;
    while (busy_o && cyc < 500) begin
      cyc++;
      if (offs_valid_o[0]) v0++;
      if (offs_valid_o[1]) v1++;
      if (done_o) dn++;
      if (ctrl_uloop_o.clear) clr++;
      if (ctrl_uloop_o.enable && first_en == 0) first_en = cyc;
      start_i   = j.busy_start && (cyc == 5);
      cons_en_i = 2'b00;
      @(negedge clk);
    end
    start_i = 1'b0;
    check("job_busy_cycles", cyc, j.exp_busy);
    check("job_valid0_cycles", v0, j.exp_v0);
    check("job_valid1_cycles", v1, j.exp_v1);
    check("job_done_pulses", dn, 1);
    check("job_clear_pulses", clr, 1);
    check("job_first_enable", first_en, 2);
    check("job_iter", iter_o, j.steps);
    check("job_last", last_o, 1);
    check("job_sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int cyc;
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; cons_en_i = 2'b00;

    //              steps en     d0 d1 bstart busy v0 v1
    jobs[0] = '{1, 2'b11, 0, 0, 1'b0, 4,  1, 1};
    jobs[1] = '{4, 2'b11, 0, 3, 1'b1, 22, 4, 16};
    jobs[2] = '{3, 2'b00, 0, 0, 1'b0, 8,  0, 0};
    jobs[3] = '{2, 2'b01, 2, 5, 1'b0, 10, 6, 0};
    jobs[4] = '{2, 2'b10, 4, 1, 1'b0, 8,  0, 4};

    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check("rst_ctrl",  ctrl_uloop_o, 0);
    check("rst_valid", offs_valid_o, 0);
    check("rst_offs",  offs_o, 0);
    check("rst_idx",   idx_o, 0);
    check("rst_loop",  loop_o, 0);
    check("rst_last",  last_o, 0);
    check("rst_iter",  iter_o, 0);
    check("rst_busy",  busy_o, 0);
    check("rst_done",  done_o, 0);

    for (int i = 0; i < 5; i++) run_job(jobs[i]);

    // Start together with abort in IDLE is dropped.
    @(negedge clk);
    start_i = 1'b1; abort_i = 1'b1; cons_en_i = 2'b11;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    check("sa_busy", busy_o, 0);
    check("sa_clear", ctrl_uloop_o.clear, 0);
    @(negedge clk);
    check("sa_busy_later", busy_o, 0);
    check("sa_iter_kept", iter_o, 2);

    // Abort in DISP while consumer 1 still pending.
    dly[0] = 0; dly[1] = 3; m_steps = 4; cur_en = 2'b11;
    start_i = 1'b1; cons_en_i = 2'b11;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (offs_valid_o != 2'b10 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("ab_pending", offs_valid_o, 2'b10);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("ab_valid_dropped", offs_valid_o, 0);
    check("ab_clear_pulse", ctrl_uloop_o.clear, 1);
    check("ab_busy_1", busy_o, 1);
    check("ab_done_1", done_o, 0);
    @(negedge clk);
    check("ab_busy_2", busy_o, 0);
    check("ab_clear_end", ctrl_uloop_o.clear, 0);
    check("ab_done_2", done_o, 0);
    check("ab_iter", iter_o, 0);
    check("ab_sb_drained", sb_q.size(), 0);

    // Reset mid-STEP: a low pulse between edges is ignored, a sampled one clears.
    m_stall = 1'b1; m_steps = 3; cur_en = 2'b11; dly[0] = 0; dly[1] = 0;
    @(negedge clk);
    start_i = 1'b1; cons_en_i = 2'b11;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check("rs_in_step", ctrl_uloop_o.enable, 1);
    check("rs_offs_pre", offs_o, 64'h0004_0003_0002_0001);
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #2 rst_ni = 1'b1;
    @(negedge clk);
    check("rs_glitch_busy", busy_o, 1);
    check("rs_glitch_enable", ctrl_uloop_o.enable, 1);
    @(posedge clk);
    #1 rst_ni = 1'b0;
    @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check("rs_ctrl",  ctrl_uloop_o, 0);
    check("rs_valid", offs_valid_o, 0);
    check("rs_offs",  offs_o, 0);
    check("rs_idx",   idx_o, 0);
    check("rs_last",  last_o, 0);
    check("rs_busy",  busy_o, 0);
    check("rs_done",  done_o, 0);
    m_stall = 1'b0;

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
